tensor_core_matrix_loader: RTL and testbench
============================================

Name: tensor_core_matrix_loader

Overview:
Upstream loader for the tensor core register file. It accepts a byte stream over a valid/ready handshake and turns it into sequential single-byte register-file writes at addresses 0..NUMBER_OF_REGISTERS-1. Once the last write has landed, it pulses a compute start toward the tensor core. It then holds off the next load until the tensor core reports done, so the operands stay stable during compute.

Parameters:
NUMBER_OF_REGISTERS, 32, register-file depth in bytes; a multiple of 16 (one 4x4 byte matrix per 16); minimum 16.
ADDRESS_WIDTH, $clog2(NUMBER_OF_REGISTERS), width of the write address; derived, not overridden.

Ports:
clock_in  input  1  single clock; all state changes on its rising edge.
reset_n_in  input  1  asynchronous, active-low reset.
start_in  input  1  one-cycle request to begin a load; honoured only in IDLE.
byte_valid_in  input  1  upstream byte available.
byte_data_in  input  8  upstream byte.
byte_ready_out  output  1  loader will accept a byte this cycle.
write_enable_out  output  1  register-file write strobe.
write_register_address_out  output  ADDRESS_WIDTH  register-file write address.
write_data_out  output  8  register-file write data.
busy_out  output  1  high in every state except IDLE.
compute_start_out  output  1  one-cycle pulse: all operands are written.
compute_done_in  input  1  tensor core finished; operands may be overwritten.

Behaviour:
- Reset (async assert, sync release): state=IDLE, byte count=0, all outputs 0; write_enable_out falls with reset assertion, not at the next edge.
- States: IDLE, LOAD, FLUSH, WAIT_COMPUTE.
- IDLE: byte_ready_out=0. start_in=1 -> LOAD, count cleared to 0.
- LOAD: byte_ready_out=1, driven combinationally from state. A byte is accepted on each cycle with byte_valid_in && byte_ready_out. byte_valid_in low stalls indefinitely, with no timeout.
- Write latency is 1 cycle. A byte accepted in cycle t drives write_enable_out=1, write_register_address_out=count, write_data_out=byte during cycle t+1; all three are registered. write_enable_out=0 in any cycle with no prior-cycle accept.
- Count increments by 1 per accept. Accepting with count==NUMBER_OF_REGISTERS-1 -> FLUSH, and count wraps to 0. The address never exceeds NUMBER_OF_REGISTERS-1.
- FLUSH: byte_ready_out=0 and the last write is on the bus. Lasts exactly 1 cycle -> WAIT_COMPUTE.
- WAIT_COMPUTE: compute_start_out=1 in the first cycle only. byte_ready_out=0. compute_done_in is ignored in the first cycle and sampled from the second cycle on. compute_done_in=1 -> IDLE.
- Boundary conditions:
  - start_in outside IDLE is ignored and not queued.
  - start_in in the same cycle as the IDLE return is ignored; IDLE must be observed.
  - compute_done_in outside WAIT_COMPUTE is ignored.
  - Reset mid-LOAD or mid-WAIT discards the partial load; a new load restarts at address 0.
- Minimum turnaround: last accept at t, compute_start_out at t+2, earliest IDLE at t+4.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: adds output checksum_out [15:0]. It is the unsigned mod-2^16 sum of all bytes accepted since the last IDLE->LOAD transition, cleared on that transition and on reset. It is stable from FLUSH through WAIT_COMPUTE and holds its value in IDLE.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset_n_in low with byte_valid_in=1 -> all outputs 0. After release, byte_ready_out=0 until start_in.
- Full load, no stalls, N=32: start_in, then bytes 0x01..0x20 back-to-back -> 32 write strobes at addresses 0..31 with data 0x01..0x20, each 1 cycle after its accept. compute_start_out is a single pulse 2 cycles after the last accept. With the checksum macro, checksum_out=0x0210.
- Stall: drop byte_valid_in for 5 cycles after byte 7 -> no strobes during the gap, address 7 is followed by address 8, no duplicates.
- Hold-off: during WAIT_COMPUTE, pulse start_in and drive byte_valid_in -> byte_ready_out stays 0 and no writes occur. compute_done_in=1 -> IDLE next cycle. A new start then begins at address 0.
- Reset mid-load: assert reset_n_in after 10 accepts -> write_enable_out drops immediately and busy_out=0. After release, a new load writes from address 0.
- Early done: compute_done_in held high throughout -> the FLUSH and first WAIT cycles ignore it; IDLE is reached exactly 1 cycle after the compute_start_out pulse ends.

Source files
------------

// File: rtl/tensor_core_matrix_loader_if.sv
// Purpose : bundles the byte-stream, register-file write and compute-control
//           signals between the matrix loader and its neighbours.
// Ports   : master = the loader itself; slave = the upstream byte source,
//           the register file and the tensor core, seen as one environment.
//           With LOADER_CHECKSUM_EN defined, a 16-bit checksum_out is added.
interface tensor_core_matrix_loader_if #(
    parameter int NUMBER_OF_REGISTERS = 32
);
    localparam int ADDRESS_WIDTH = $clog2(NUMBER_OF_REGISTERS);

    // Control toward / from the tensor core
    logic                     start_in;
    logic                     busy_out;
    logic                     compute_start_out;
    logic                     compute_done_in;

    // Upstream byte stream (valid/ready)
    logic                     byte_valid_in;
    logic [7:0]               byte_data_in;
    logic                     byte_ready_out;

    // Register-file write port
    logic                     write_enable_out;
    logic [ADDRESS_WIDTH-1:0] write_register_address_out;
    logic [7:0]               write_data_out;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0]              checksum_out;

    modport master (
        input  start_in, compute_done_in, byte_valid_in, byte_data_in,
        output busy_out, compute_start_out, byte_ready_out,
               write_enable_out, write_register_address_out, write_data_out,
               checksum_out
    );

    modport slave (
        output start_in, compute_done_in, byte_valid_in, byte_data_in,
        input  busy_out, compute_start_out, byte_ready_out,
               write_enable_out, write_register_address_out, write_data_out,
               checksum_out
    );
`else
    modport master (
        input  start_in, compute_done_in, byte_valid_in, byte_data_in,
        output busy_out, compute_start_out, byte_ready_out,
               write_enable_out, write_register_address_out, write_data_out
    );

    modport slave (
        output start_in, compute_done_in, byte_valid_in, byte_data_in,
        input  busy_out, compute_start_out, byte_ready_out,
               write_enable_out, write_register_address_out, write_data_out
    );
`endif

endinterface

// File: rtl/tensor_core_matrix_loader.sv
// Purpose : turns an upstream byte stream into sequential register-file writes
//           at addresses 0..NUMBER_OF_REGISTERS-1, then pulses compute start
//           and holds off the next load until the tensor core reports done.
// Latency : a byte accepted in cycle t is written (registered strobe) in t+1;
//           compute_start_out fires at t+2 after the last accept.
// Backpressure: byte_ready_out is high only in LOAD; an idle upstream
//           (byte_valid_in low) stalls the load indefinitely.
//
// Ports   : clock_in, reset_n_in (async active-low) as plain ports; everything
//           else through tensor_core_matrix_loader_if.master (start/busy,
//           byte stream, register-file write bus, compute start/done).
// Option  : define LOADER_CHECKSUM_EN to add checksum_out, the mod-2^16 sum of
//           the bytes accepted in the current/most recent load.
module tensor_core_matrix_loader #(
    parameter  int NUMBER_OF_REGISTERS = 32,
    localparam int ADDRESS_WIDTH       = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    tensor_core_matrix_loader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        WAIT_COMPUTE
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS =
        ADDRESS_WIDTH'(NUMBER_OF_REGISTERS - 1);

    state_t                     state;
    logic [ADDRESS_WIDTH-1:0]   count;
    logic                       write_enable_q;
    logic [ADDRESS_WIDTH-1:0]   write_address_q;
    logic [7:0]                 write_data_q;
    logic                       compute_start_q;

    logic                       byte_ready;
    logic                       accept;

    // Ready comes straight from the state register so upstream sees it in
    // the same cycle LOAD is entered.
    assign byte_ready = (state == LOAD);
    assign accept     = bus.byte_valid_in && byte_ready;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state           <= IDLE;
            count           <= '0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= 8'h00;
            compute_start_q <= 1'b0;
        end else begin
            // Write bus mirrors the previous cycle's accept; address and data
            // only move on an accept so they stay stable between strobes.
            write_enable_q  <= accept;
            if (accept) begin
                write_address_q <= count;
                write_data_q    <= bus.byte_data_in;
            end

            compute_start_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        state <= LOAD;
                        count <= '0;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        if (count == LAST_ADDRESS) begin
                            count <= '0;
                            state <= FLUSH;
                        end else begin
                            count <= count + ADDRESS_WIDTH'(1);
                        end
                    end
                end

                // One cycle for the final write to land before compute starts.
                FLUSH: begin
                    state           <= WAIT_COMPUTE;
                    compute_start_q <= 1'b1;
                end

                // compute_start_q is high exactly in the first WAIT_COMPUTE
                // cycle, so it doubles as the "ignore done this cycle" flag:
                // a stale done from the previous job cannot end this one.
                WAIT_COMPUTE: begin
                    if (!compute_start_q && bus.compute_done_in) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready_out             = byte_ready;
    assign bus.busy_out                   = (state != IDLE);
    assign bus.write_enable_out           = write_enable_q;
    assign bus.write_register_address_out = write_address_q;
    assign bus.write_data_out             = write_data_q;
    assign bus.compute_start_out          = compute_start_q;

`ifdef LOADER_CHECKSUM_EN
    // Cleared on IDLE->LOAD; only accepts change it, so it naturally holds
    // through FLUSH, WAIT_COMPUTE and the following IDLE.
    logic [15:0] checksum_q;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            checksum_q <= 16'h0000;
        end else if (state == IDLE && bus.start_in) begin
            checksum_q <= 16'h0000;
        end else if (accept) begin
            checksum_q <= checksum_q + {8'h00, bus.byte_data_in};
        end
    end

    assign bus.checksum_out = checksum_q;
`endif

endmodule

// File: tb/tb_tensor_core_matrix_loader.sv
// Purpose : randomized self-checking bench for tensor_core_matrix_loader.
// Latency : expectations are keyed by absolute cycle number.
// Backpressure: stalls are injected by dropping byte_valid_in at random.
module tb_tensor_core_matrix_loader;

    localparam int N  = 32;
    localparam int AW = $clog2(N);

    logic clock_in = 1'b0;
    logic reset_n_in;

    always #5 clock_in = ~clock_in;

    tensor_core_matrix_loader_if #(.NUMBER_OF_REGISTERS(N)) bus_if ();

    tensor_core_matrix_loader #(.NUMBER_OF_REGISTERS(N)) dut (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .bus        (bus_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: expected register-file writes and compute-start pulses,
    // each tagged with the cycle in which it must appear on the outputs.
    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t wq[$];
    int  csq[$];
    bit  mon_en    = 1'b0;
    bit  exp_ready = 1'b0;
    bit  exp_busy  = 1'b0;

    always @(negedge clock_in) begin
        if (mon_en) begin
            check("byte_ready", bus_if.byte_ready_out, exp_ready);
            check("busy", bus_if.busy_out, exp_busy);
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                check("wr_en", bus_if.write_enable_out, 1);
                check("wr_addr", bus_if.write_register_address_out, wq[0].addr);
                check("wr_data", bus_if.write_data_out, wq[0].data);
                wq.delete(0);
            end else begin
                check("wr_en_idle", bus_if.write_enable_out, 0);
            end
            if (csq.size() > 0 && csq[0] == cyc) begin
                check("compute_start", bus_if.compute_start_out, 1);
                csq.delete(0);
            end else begin
                check("compute_start_idle", bus_if.compute_start_out, 0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock_in);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            bus_if.start_in        = 1'b0;
            bus_if.byte_valid_in   = 1'($urandom_range(0, 1));
            bus_if.byte_data_in    = 8'($urandom_range(0, 255));
            bus_if.compute_done_in = 1'($urandom_range(0, 1));
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first
    // IDLE cycle after the job completes.
    task automatic do_load(input bit seq_data, input int stall_pct, input bit gap_after_7,
                           input bit early_done, input int extra_wait);
        int        k;
        int        sum;
        int        gap;
        int        t;
        bit        v;
        logic [7:0] d;
        wr_t       e;
        k   = 0;
        sum = 0;
        gap = 0;

        bus_if.start_in        = 1'b1;
        bus_if.byte_valid_in   = 1'($urandom_range(0, 1));
        bus_if.compute_done_in = 1'($urandom_range(0, 1));
        exp_ready = 1'b0;
        exp_busy  = 1'b0;

        while (k < N) begin
            next_cycle();
            bus_if.start_in        = 1'($urandom_range(0, 1));
            bus_if.compute_done_in = 1'($urandom_range(0, 1));
            exp_ready = 1'b1;
            exp_busy  = 1'b1;
            if (gap > 0) begin
                v = 1'b0;
                gap--;
            end else begin
                v = ($urandom_range(0, 99) >= stall_pct);
            end
            d = seq_data ? 8'(k + 1) : 8'($urandom_range(0, 255));
            bus_if.byte_valid_in = v;
            bus_if.byte_data_in  = d;
            if (v) begin
                e.cyc  = cyc + 1;
                e.addr = k;
                e.data = d;
                wq.push_back(e);
                sum += d;
                k++;
                if (gap_after_7 && k == 8) gap = 5;
            end
        end
        t = cyc;
        csq.push_back(t + 2);

        // FLUSH
        next_cycle();
        bus_if.start_in        = 1'($urandom_range(0, 1));
        bus_if.byte_valid_in   = 1'($urandom_range(0, 1));
        bus_if.compute_done_in = early_done ? 1'b1 : 1'($urandom_range(0, 1));
        exp_ready = 1'b0;
        exp_busy  = 1'b1;

        // First WAIT_COMPUTE cycle: done must be ignored here
        next_cycle();
        bus_if.start_in        = 1'($urandom_range(0, 1));
        bus_if.byte_valid_in   = 1'($urandom_range(0, 1));
        bus_if.compute_done_in = early_done ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef LOADER_CHECKSUM_EN
        check("checksum_wait", bus_if.checksum_out, sum & 16'hFFFF);
`endif

        for (int i = 0; i < (early_done ? 0 : extra_wait); i++) begin
            next_cycle();
            bus_if.start_in        = 1'($urandom_range(0, 1));
            bus_if.byte_valid_in   = 1'($urandom_range(0, 1));
            bus_if.compute_done_in = 1'b0;
        end

        // Done cycle, with a start that must not be honoured
        next_cycle();
        bus_if.start_in        = 1'b1;
        bus_if.byte_valid_in   = 1'($urandom_range(0, 1));
        bus_if.compute_done_in = 1'b1;
        if (early_done) check("early_done_turnaround", cyc, t + 3);

        // Back in IDLE
        next_cycle();
        bus_if.start_in        = 1'b0;
        bus_if.byte_valid_in   = 1'($urandom_range(0, 1));
        bus_if.compute_done_in = early_done ? 1'b1 : 1'($urandom_range(0, 1));
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        check("checksum_idle", bus_if.checksum_out, sum & 16'hFFFF);
`endif
    endtask

    task automatic reset_mid_load(input int accepts);
        wr_t e;
        bus_if.start_in = 1'b1;
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        for (int k = 0; k < accepts; k++) begin
            next_cycle();
            bus_if.start_in      = 1'b0;
            bus_if.byte_valid_in = 1'b1;
            bus_if.byte_data_in  = 8'($urandom_range(0, 255));
            exp_ready = 1'b1;
            exp_busy  = 1'b1;
            e.cyc  = cyc + 1;
            e.addr = k;
            e.data = bus_if.byte_data_in;
            wq.push_back(e);
        end
        next_cycle();
        // The last accepted write is on the bus now; reset must kill it at once.
        check("mid_wr_en_before", bus_if.write_enable_out, 1);
        mon_en = 1'b0;
        wq.delete();
        csq.delete();
        reset_n_in = 1'b0;
        #1;
        check("mid_rst_wr_en", bus_if.write_enable_out, 0);
        check("mid_rst_busy", bus_if.busy_out, 0);
        check("mid_rst_ready", bus_if.byte_ready_out, 0);
        check("mid_rst_cstart", bus_if.compute_start_out, 0);
`ifdef LOADER_CHECKSUM_EN
        check("mid_rst_checksum", bus_if.checksum_out, 0);
`endif
        repeat (2) next_cycle();
        reset_n_in = 1'b1;
        bus_if.byte_valid_in = 1'b0;
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        reset_n_in             = 1'b0;
        bus_if.start_in        = 1'b0;
        bus_if.byte_valid_in   = 1'b1;
        bus_if.byte_data_in    = 8'hA5;
        bus_if.compute_done_in = 1'b0;
        #3;
        check("rst_ready", bus_if.byte_ready_out, 0);
        check("rst_wr_en", bus_if.write_enable_out, 0);
        check("rst_wr_addr", bus_if.write_register_address_out, 0);
        check("rst_wr_data", bus_if.write_data_out, 0);
        check("rst_busy", bus_if.busy_out, 0);
        check("rst_cstart", bus_if.compute_start_out, 0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", bus_if.checksum_out, 0);
`endif
        repeat (3) next_cycle();
        reset_n_in = 1'b1;
        mon_en     = 1'b1;
        idle_cycles(3);

        // Full back-to-back load of 0x01..0x20 (checksum 0x0210)
        do_load(1'b1, 0, 1'b0, 1'b0, 2);
        idle_cycles(2);
        // Five-cycle stall after address 7, with hold-off traffic while waiting
        do_load(1'b1, 0, 1'b1, 1'b0, 4);
        idle_cycles(1);
        reset_mid_load(10);
        idle_cycles(2);
        do_load(1'b0, 25, 1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            idle_cycles($urandom_range(0, 3));
            do_load(1'b0, 30, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end
        idle_cycles(3);
        check("pending_writes", wq.size(), 0);
        check("pending_cstart", csq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
